disp_scan_ctrl: RTL
===================

# disp_scan_ctrl

Time-multiplexing controller for the 4-digit 7-segment display of the clock/alarm.
- Drives the select of the 4:1 nibble mux that chooses among the four BCD digits, and reads that mux's output back.
- Generates the active-low digit anodes and the colon, with anti-ghosting guard time, per-digit blink for set mode, and leading-zero blanking of the most significant digit.
- Sits between the timekeeping/alarm registers (through the digit mux) and the BCD-to-segment decoder.

## Interface
- REFRESH_DIV, 100000: clock cycles per digit slot; legal range 4..2^20.
- GUARD_CYCLES, 2: cycles at the start of each slot with all anodes off; legal range 1..REFRESH_DIV-2.
- BLINK_FRAMES, 64: full scan frames per blink half-period; legal range ≥1.
- clk  in  1  system clock; every register updates on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  display enable; 0 blanks the display and freezes the scan.
- blink_en  in  4  per-digit blink request, bit i = digit i.
- lz_blank  in  1  suppress digit 3 when its value is 0.
- colon_en  in  1  colon (dp of digit 2) request.
- digit_val  in  4  current output of the digit mux; must correspond to `sel` in the same cycle.
- sel  out  2  digit mux select and current slot index.
- an_n  out  4  anode enables, active-low, at most one bit low at any time.
- dp_n  out  1  decimal point / colon, active-low.
- frame_tick  out  1  one-cycle pulse at the start of each frame.
- blink_phase  out  1  0 = visible half, 1 = dark half.

## Operation
- State machine has three states: IDLE, GUARD, ON. A slot counter `cnt` is sized to fit REFRESH_DIV-1. A frame counter is sized to fit BLINK_FRAMES-1.
- Reset values: state IDLE, cnt 0, sel 0, frame counter 0, blink_phase 0, frame_tick 0. Resulting outputs: an_n 4'hF, dp_n 1.
- IDLE → GUARD when en=1, with cnt=0.
- GUARD → ON when cnt==GUARD_CYCLES-1.
- ON → GUARD when cnt==REFRESH_DIV-1. On this transition, cnt is set to 0 and sel advances modulo 4 (3 wraps to 0).
- In GUARD and ON, cnt increments every cycle, except as noted at the slot wrap.
- Any state → IDLE in the cycle after en=0. On entry, cnt is cleared and sel, blink_phase and the frame counter hold. Re-enabling always starts a fresh slot at the held sel.
- an_n and dp_n are combinational decodes of registered state, sel and blink_phase, plus digit_val:
  - an_n[sel]=0 only if state==ON and neither suppression applies. All other bits are 1.
  - Blink suppression: blink_en[sel]=1 and blink_phase=1.
  - Leading-zero suppression: lz_blank=1, sel==3 and digit_val==0.
  - dp_n=0 only if state==ON, sel==2, colon_en=1 and blink_phase=0.
- frame_tick is registered. It is set high for one cycle by the ON→GUARD transition that wraps sel 3→0, so it coincides with the first GUARD cycle of slot 0. No tick fires after reset or on re-enable.
- The frame counter increments on every frame_tick. When it wraps from BLINK_FRAMES-1 to 0, blink_phase toggles on the same edge.
- Simultaneous events:
  - rst dominates en.
  - en=0 in the same cycle as a slot wrap goes to IDLE, and sel still does not advance.
  - Changes to blink_en, lz_blank and colon_en take effect combinationally in the current slot.

## Timing
- Slot length is exactly REFRESH_DIV cycles: GUARD_CYCLES dark, then REFRESH_DIV-GUARD_CYCLES lit.
- Frame length is 4·REFRESH_DIV cycles. Blink period is 8·REFRESH_DIV·BLINK_FRAMES cycles.
- sel and an_n change on the same edge, and a new anode is never enabled in the first GUARD_CYCLES cycles after sel changes. This gives the digit mux and segment decoder at least one full cycle to settle.
- Startup latency from rst release with en=1: one cycle in IDLE, GUARD_CYCLES cycles in GUARD, then the first anode is lit.
- Disabling takes effect on the cycle after en falls: an_n=F, dp_n=1.

## Structure
- Shared package disp_pkg holds:
  - the state encoding (IDLE/GUARD/ON);
  - AN_OFF = 4'hF;
  - DIG_COLON = 2 and DIG_MSD = 3;
  - the active-low polarity constant reused by the segment decoder.
- One natural sub-module, blink_gen: frame counter plus blink_phase toggle, driven by frame_tick. Everything else stays in disp_scan_ctrl.
- The digit mux remains a separate instance at the parent level. The block does not embed it.

## Test plan
Bench parameters: REFRESH_DIV=8, GUARD_CYCLES=2, BLINK_FRAMES=2.
- Reset then scan: rst=1 for 3 cycles with en=1, then release. Required response:
  - an_n=F for 3 cycles after release (1 IDLE, 2 GUARD), then 4'b1110 for 6 cycles;
  - sel=1 with an_n=F for 2 cycles, then 4'b1101;
  - frame_tick pulses exactly once every 32 cycles, on the first GUARD cycle of sel=0.
- Blink: blink_en=4'b0011. Required response:
  - digits 0 and 1 are dark during frames where blink_phase=1 (blink_phase toggles every 2 frames);
  - digits 2 and 3 are lit every frame.
- Leading zero: lz_blank=1.
  - digit_val=0 in slot 3 → an_n stays F for the whole slot.
  - digit_val=5 in slot 3 → an_n=4'b0111.
  - lz_blank=0 with digit_val=0 → 4'b0111.
- Colon: colon_en=1. dp_n=0 only during the lit part of slot 2 with blink_phase=0, and 1 otherwise.
- Enable drop: en=0 at sel=2, cnt=5. Required response:
  - the next cycle gives an_n=F and dp_n=1, with sel held at 2;
  - after en returns to 1: 1 IDLE cycle, 2 GUARD cycles, then 4'b1011 for 6 cycles before sel=3.
- Mid-operation reset: assert rst during ON at sel=3 with blink_phase=1. The next cycle shows IDLE, sel=0, blink_phase=0, an_n=F and frame_tick=0.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared definitions for the 7-segment display scan path.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GUARD = 2'd1,
        ST_ON    = 2'd2
    } scan_state_t;

    localparam logic [3:0] AN_OFF    = 4'hF;
    localparam logic [1:0] DIG_COLON = 2'd2;
    localparam logic [1:0] DIG_MSD   = 2'd3;

    // Anodes, dp and segments are all active-low on this board.
    localparam logic SEG_ON  = 1'b0;
    localparam logic SEG_OFF = 1'b1;

endpackage

// File: rtl/disp_scan_ctrl_if.sv
// Scan controller <-> display path bundle (controls in, digit mux readback, drive outputs).
// Latency: n/a (wiring only).
// Backpressure: none; every signal is level-sampled each cycle.
interface disp_scan_ctrl_if;
    logic       en;
    logic [3:0] blink_en;
    logic       lz_blank;
    logic       colon_en;
    logic [3:0] digit_val;
    logic [1:0] sel;
    logic [3:0] an_n;
    logic       dp_n;
    logic       frame_tick;
    logic       blink_phase;

    modport master (
        input  en, blink_en, lz_blank, colon_en, digit_val,
        output sel, an_n, dp_n, frame_tick, blink_phase
    );

    modport slave (
        output en, blink_en, lz_blank, colon_en, digit_val,
        input  sel, an_n, dp_n, frame_tick, blink_phase
    );
endinterface

// File: rtl/disp_scan_ctrl_blink.sv
// Frame counter that toggles blink_phase every BLINK_FRAMES frame ticks.
// Latency: blink_phase updates on the edge that samples the wrapping frame_tick.
// Backpressure: none; frame_tick is a free-running pulse.
module blink_gen #(
    parameter int BLINK_FRAMES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_tick,
    output logic blink_phase
);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    logic [FW-1:0] frame_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_tick) begin
            if (frame_cnt == FRAME_LAST) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + FW'(1);
            end
        end
    end
endmodule

// File: rtl/disp_scan_ctrl.sv
// 4-digit multiplexed display scanner: guard-then-lit slots, blink, colon, leading-zero blank.
// Latency: first anode lit GUARD_CYCLES+1 cycles after enable; disable blanks on the next cycle.
// Backpressure: none; free-running scan, en freezes it.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic               clk,
    input  logic               rst,
    disp_scan_ctrl_if.master   disp
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);

    scan_state_t   state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    sel, sel_nxt;
    logic          frame_tick, tick_nxt;
    logic          blink_phase;
    logic          blink_sup, lz_sup;
    logic [3:0]    an_n;
    logic          dp_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            sel        <= 2'd0;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            sel        <= sel_nxt;
            frame_tick <= tick_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sel_nxt   = sel;
        tick_nxt  = 1'b0;
        if (!disp.en) begin
            // Drop wins over a coincident slot wrap: sel is held for re-enable.
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    state_nxt = ST_GUARD;
                    cnt_nxt   = '0;
                end
                ST_GUARD: begin
                    cnt_nxt = cnt + CW'(1);
                    if (cnt == GUARD_LAST) state_nxt = ST_ON;
                end
                ST_ON: begin
                    if (cnt == CNT_LAST) begin
                        state_nxt = ST_GUARD;
                        cnt_nxt   = '0;
                        sel_nxt   = sel + 2'd1;
                        tick_nxt  = (sel == DIG_MSD);
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    blink_gen #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
        .clk         (clk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .blink_phase (blink_phase)
    );

    // digit_val is the mux readback for the current sel, so blanking tracks it combinationally.
    always_comb begin
        an_n      = AN_OFF;
        dp_n      = SEG_OFF;
        blink_sup = disp.blink_en[sel] & blink_phase;
        lz_sup    = disp.lz_blank && (sel == DIG_MSD) && (disp.digit_val == 4'd0);
        if (state == ST_ON && !blink_sup && !lz_sup) an_n[sel] = SEG_ON;
        if (state == ST_ON && sel == DIG_COLON && disp.colon_en && !blink_phase) dp_n = SEG_ON;
    end

    assign disp.sel         = sel;
    assign disp.an_n        = an_n;
    assign disp.dp_n        = dp_n;
    assign disp.frame_tick  = frame_tick;
    assign disp.blink_phase = blink_phase;
endmodule
